disp_scan: RTL and testbench

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/disp_pkg.sv | 31 +++
 rtl/bin2bcd.sv | 53 +++++
 rtl/disp_scan.sv | 169 ++++++++++++++++
 tb/tb_disp_scan.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package disp_pkg;

  localparam int NDIG = 4;

  // Digit codes understood by the downstream 7-segment decoder.
  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd15;

  // Double-dabble iteration count equals the input width.
  localparam int VAL_W    = 14;
  localparam int BCD_ITER = VAL_W;

  // Most negative value that still fits "-999" on four digits. The upper
  // bound 9999 exceeds the 14-bit signed range, so it never needs a check.
  localparam logic signed [VAL_W-1:0] VAL_MIN = -14'sd999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3).
// Latency: start at edge N, one iteration per edge N+1..N+14; o_done marks the final iteration cycle.
// Backpressure: none; a new start restarts the conversion unconditionally.
// Ports: i_clk/i_reset (async, active-high), i_start + i_bin (load operand),
//        o_done (high during the cycle whose closing edge performs the last shift),
//        o_bcd (four BCD nibbles, digit 0 in bits [3:0]).
module bin2bcd (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [13:0] i_bin,
  output logic        o_done,
  output logic [15:0] o_bcd
);
  import disp_pkg::*;

  // {bcd[15:0], bin[13:0]} shifted left as one register.
  logic [29:0] r_shift;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [29:0] w_adj;

  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < 4; i++) begin
      w_adj[14 + 4*i +: 4] = add3(r_shift[14 + 4*i +: 4]);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_shift <= {16'd0, i_bin};
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_shift <= {w_adj[28:0], 1'b0};
      r_cnt   <= r_cnt + 4'd1;
      if (r_cnt == 4'(BCD_ITER - 1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Asserted one cycle early so the caller can schedule its commit on the
  // edge right after the last shift lands.
  assign o_done = r_busy && (r_cnt == 4'(BCD_ITER - 1));
  assign o_bcd  = r_shift[29:14];

endmodule

// File: rtl/disp_scan.sv
// Signed 14-bit value to 4-digit multiplexed 7-segment display scanner.
// Latency: load at edge N, busy for 15 cycles, display registers updated at edge N+15.
// Backpressure: load is ignored while busy; scanning never stalls.
// Ports: clk, reset (async, active-high); value/dp_en/dp_pos/load capture request;
//        busy; num/decimal/digit_en registered drive to the digit decoder and commons.
module disp_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int NDIG     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic        dp_en,
  input  logic [1:0]  dp_pos,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  num,
  output logic        decimal,
  output logic [3:0]  digit_en
);
  import disp_pkg::*;

  localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  state_t r_state;
  state_t w_state_next;
  logic   w_start;
  logic   w_commit;

  // Request captured at load
  logic       r_dp_en;
  logic [1:0] r_dp_pos;
  logic       r_neg;
  logic       r_oor;

  logic [13:0]     w_mag;
  logic            w_oor;
  logic            w_bcd_done;
  logic [3:0][3:0] w_bcd;

  logic [2:0]      w_width;
  logic            w_show_dash;
  logic [3:0][3:0] w_new_disp;
  logic [3:0][3:0] w_disp_next;
  logic [3:0][3:0] r_disp;

  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_next;
  logic             w_tick;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (load) w_state_next = CONV;
      CONV:    if (w_bcd_done) w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy     = (r_state != IDLE);
    w_start  = (r_state == IDLE) && load;
    w_commit = (r_state == COMMIT);
  end

  // ---------------- Capture ----------------
  // Magnitude stays 14 bits: -8192 maps to 14'h2000 without overflow.
  assign w_mag = value[13] ? (~value + 14'd1) : value;
  assign w_oor = ($signed(value) < VAL_MIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dp_en  <= 1'b0;
      r_dp_pos <= 2'd0;
      r_neg    <= 1'b0;
      r_oor    <= 1'b0;
    end else if (w_start) begin
      r_dp_en  <= dp_en;
      r_dp_pos <= dp_pos;
      r_neg    <= value[13];
      r_oor    <= w_oor;
    end
  end

  bin2bcd u_bin2bcd (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (w_start),
    .i_bin   (w_mag),
    .o_done  (w_bcd_done),
    .o_bcd   (w_bcd)
  );

  // ---------------- Digit composition ----------------
  // w_width = number of digits shown (leading-zero blanking), widened so
  // the decimal point always has a digit to its left down to digit 0.
  // A negative number whose digits fill all four slots leaves nowhere for
  // the minus sign, so it is shown as dashes like any other overflow.
  always_comb begin
    w_width = 3'd1;
    if (w_bcd[1] != 4'd0) w_width = 3'd2;
    if (w_bcd[2] != 4'd0) w_width = 3'd3;
    if (w_bcd[3] != 4'd0) w_width = 3'd4;
    if (r_dp_en && (({1'b0, r_dp_pos} + 3'd1) > w_width)) begin
      w_width = {1'b0, r_dp_pos} + 3'd1;
    end
    w_show_dash = r_oor || (r_neg && (w_width == 3'd4));

    w_new_disp = {4{DIG_BLANK}};
    for (int i = 0; i < 4; i++) begin
      if (w_show_dash) begin
        w_new_disp[i] = DIG_MINUS;
      end else if (3'(i) < w_width) begin
        w_new_disp[i] = w_bcd[i];
      end else if (r_neg && (3'(i) == w_width)) begin
        w_new_disp[i] = DIG_MINUS;
      end else begin
        w_new_disp[i] = DIG_BLANK;
      end
    end
  end

  // The output stage reads the post-commit register image so a commit on a
  // scan tick never shows the old digit at the new index.
  assign w_disp_next = w_commit ? w_new_disp : r_disp;

  // ---------------- Scan ----------------
  assign w_tick = (r_scan_cnt == CNT_LAST);

  always_comb begin
    w_idx_next = r_idx;
    if (w_tick) begin
      w_idx_next = (r_idx == 2'(NDIG - 1)) ? 2'd0 : (r_idx + 2'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
      r_disp     <= {4{DIG_BLANK}};
      num        <= DIG_BLANK;
      digit_en   <= 4'b0001;
      decimal    <= 1'b0;
    end else begin
      r_scan_cnt <= w_tick ? '0 : (r_scan_cnt + 1'b1);
      r_idx      <= w_idx_next;
      r_disp     <= w_disp_next;
      num        <= w_disp_next[w_idx_next];
      digit_en   <= 4'b0001 << w_idx_next;
      decimal    <= r_dp_en && (r_dp_pos == w_idx_next);
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: stimulus pushes expected display images,
// a negedge monitor pops them when busy falls and checks every scan cycle.
module tb_disp_scan;

  localparam int SCAN_DIV = 4;

  typedef logic [15:0] disp_t;   // digit i at [4*i +: 4]

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] value;
  logic        dp_en;
  logic [1:0]  dp_pos;
  logic        load;
  logic        busy;
  logic [3:0]  num;
  logic        decimal;
  logic [3:0]  digit_en;

  always #5 clk = ~clk;

  disp_scan #(.SCAN_DIV(SCAN_DIV), .NDIG(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .dp_en    (dp_en),
    .dp_pos   (dp_pos),
    .load     (load),
    .busy     (busy),
    .num      (num),
    .decimal  (decimal),
    .digit_en (digit_en)
  );

  int    checks = 0;
  int    errors = 0;
  disp_t exp_q[$];
  int    cap_en  = 0;
  int    cap_pos = 0;
  int    k = 0;            // edges since reset release
  int    mon_idx;
  disp_t cur;
  logic  prev_busy;
  int    p10[5] = '{1, 10, 100, 1000, 10000};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what four digit slots should show for a signed value.
  function automatic disp_t model(input int v, input int de, input int dpos);
    int    mag;
    int    w;
    disp_t d;
    if (v > 9999 || v < -999) return {4{4'd10}};
    mag = (v < 0) ? -v : v;
    w = 1;
    while (w < 4 && mag >= p10[w]) w++;
    if (de != 0 && dpos + 1 > w) w = dpos + 1;
    if (v < 0 && w == 4) return {4{4'd10}};
    for (int i = 0; i < 4; i++) begin
      if (i < w)                 d[4*i +: 4] = 4'((mag / p10[i]) % 10);
      else if (v < 0 && i == w)  d[4*i +: 4] = 4'd10;
      else                       d[4*i +: 4] = 4'd15;
    end
    return d;
  endfunction

  function automatic int as_signed(input logic [13:0] raw);
    logic signed [13:0] s;
    int v;
    s = raw;
    v = s;
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  // Monitor: scan position derives from elapsed cycles, digits from the
  // most recently committed expectation.
  always @(negedge clk) begin
    if (reset) begin
      cur       = {4{4'd15}};
      prev_busy = 1'b0;
    end else begin
      mon_idx = (k / SCAN_DIV) % 4;
      if (prev_busy && !busy) begin
        check("commit_has_expectation", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
      end
      check("digit_en", int'(digit_en), 1 << mon_idx);
      check("num", int'(num), int'(cur[4*mon_idx +: 4]));
      if (!busy) check("decimal", int'(decimal), int'(cap_en != 0 && cap_pos == mon_idx));
      prev_busy = busy;
    end
  end

  task automatic issue_load(input logic [13:0] v, input logic de, input logic [1:0] pos,
                            output bit acc);
    @(posedge clk); #2;
    value = v; dp_en = de; dp_pos = pos; load = 1'b1;
    acc = !busy;
    if (acc) exp_q.push_back(model(as_signed(v), int'(de), int'(pos)));
    @(posedge clk); #2;
    load = 1'b0;
    if (acc) begin
      cap_en  = int'(de);
      cap_pos = int'(pos);
    end
  endtask

  task automatic wait_idle(input int exp_cycles);
    int n;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check("busy_cycles", n, exp_cycles);
  endtask

  task automatic run_one(input logic [13:0] v, input logic de, input logic [1:0] pos,
                         input int linger);
    bit acc;
    issue_load(v, de, pos, acc);
    check("load_accepted", int'(busy), 1);
    wait_idle(15);
    repeat (linger) @(posedge clk);
  endtask

  initial begin
    bit acc;
    reset = 1'b1; load = 1'b0; value = '0; dp_en = 1'b0; dp_pos = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_num", int'(num), 15);
    check("rst_digit_en", int'(digit_en), 1);
    check("rst_decimal", int'(decimal), 0);
    @(posedge clk); #2 reset = 1'b0;

    // Directed patterns, each followed by a full scan round
    run_one(14'd1234, 1'b0, 2'd0, 16);
    run_one(14'(-42), 1'b0, 2'd0, 16);
    run_one(14'd0, 1'b0, 2'd0, 16);
    run_one(14'd5, 1'b1, 2'd2, 16);
    run_one(14'(10000), 1'b0, 2'd0, 16);
    run_one(14'(-1000), 1'b0, 2'd0, 16);
    run_one(14'(-8192), 1'b1, 2'd1, 16);
    run_one(14'd8191, 1'b1, 2'd3, 16);
    run_one(14'(-999), 1'b0, 2'd0, 16);
    run_one(14'(-7), 1'b1, 2'd1, 16);

    // Commit lands exactly on a scan tick
    for (int a = 0; a < 4; a++) begin
      while ((k % SCAN_DIV) != SCAN_DIV - 1) begin
        @(posedge clk); #2;
      end
      run_one(14'(500 + 111 * a), 1'b1, 2'(a), a);
    end

    // Second load while busy must be ignored
    issue_load(14'd1234, 1'b0, 2'd0, acc);
    repeat (3) @(posedge clk);
    issue_load(14'd7777, 1'b1, 2'd1, acc);
    check("second_load_ignored", int'(acc), 0);
    wait_idle(10);
    repeat (16) @(posedge clk);

    // Reset mid-conversion aborts; load right after release is taken
    issue_load(14'd4321, 1'b1, 2'd2, acc);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    cap_en = 0; cap_pos = 0;
    check("abort_busy", int'(busy), 0);
    check("abort_num", int'(num), 15);
    check("abort_digit_en", int'(digit_en), 1);
    check("abort_decimal", int'(decimal), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    value = 14'd99; dp_en = 1'b0; dp_pos = 2'd0; load = 1'b1;
    exp_q.push_back(model(99, 0, 0));
    @(posedge clk); #2;
    load = 1'b0;
    check("load_after_reset", int'(busy), 1);
    wait_idle(15);
    repeat (16) @(posedge clk);

    // Randomized loads with random gaps
    for (int r = 0; r < 40; r++) begin
      logic [13:0] v;
      if ($urandom_range(0, 1) == 0) v = 14'(int'($urandom_range(0, 9190)) - 999);
      else                           v = 14'($urandom);
      run_one(v, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 20)));
    end

    repeat (20) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
